// File: rtl/router_reg.sv
// Datapath register block of the 1x3 router: captures the header, forwards bytes to the FIFO,
// parks one byte while the FIFO is full and checks running XOR parity against the parity byte.
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pkt_valid,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  lfd_state,
    input  logic                  rst_int_reg,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  err,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] header_byte;
    logic [DATA_WIDTH-1:0] full_byte;
    logic [DATA_WIDTH-1:0] internal_parity;
    logic [DATA_WIDTH-1:0] packet_parity;

    // Address 3 has no destination port, so such a header is never latched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            header_byte <= '0;
        end else if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
            header_byte <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out  <= '0;
            full_byte <= '0;
        end else if (lfd_state) begin
            data_out <= header_byte;
        end else if (ld_state && !fifo_full) begin
            data_out <= data_in;
        end else if (ld_state && fifo_full) begin
            full_byte <= data_in;
        end else if (laf_state) begin
            data_out <= full_byte;
        end
    end

    // The parity byte arrives with pkt_valid low, so it is never folded into the running XOR.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            internal_parity <= '0;
        end else if (detect_add) begin
            internal_parity <= '0;
        end else if (lfd_state) begin
            internal_parity <= internal_parity ^ header_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            internal_parity <= internal_parity ^ data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            packet_parity <= '0;
        end else if (detect_add) begin
            packet_parity <= '0;
        end else if (ld_state && !pkt_valid) begin
            packet_parity <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            low_pkt_valid <= 1'b0;
        end else if (rst_int_reg) begin
            low_pkt_valid <= 1'b0;
        end else if (ld_state && !pkt_valid) begin
            low_pkt_valid <= 1'b1;
        end
    end

    // A parity byte held back by a full FIFO is only done once it drains in LOAD_AFTER_FULL.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            parity_done <= 1'b0;
        end else if (detect_add) begin
            parity_done <= 1'b0;
        end else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid && !parity_done)) begin
            parity_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else begin
            err <= parity_done && (internal_parity != packet_parity);
        end
    end

endmodule

// File: tb/tb_router_reg.sv
// Directed self-checking bench for router_reg: good/bad packets, FIFO-full hold, invalid address,
// next-packet clearing and asynchronous reset.
module tb_router_reg;

    logic       clk;
    logic       rstn;
    logic       pkt_valid;
    logic       fifo_full;
    logic       detect_add;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       lfd_state;
    logic       rst_int_reg;
    logic [7:0] data_in;
    logic       err;
    logic       parity_done;
    logic       low_pkt_valid;
    logic [7:0] data_out;

    int vec_cnt = 0;
    int err_cnt = 0;

    router_reg #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pkt_valid    (pkt_valid),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .lfd_state    (lfd_state),
        .rst_int_reg  (rst_int_reg),
        .data_in      (data_in),
        .err          (err),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .data_out     (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        pkt_valid   = 1'b0;
        fifo_full   = 1'b0;
        detect_add  = 1'b0;
        ld_state    = 1'b0;
        laf_state   = 1'b0;
        full_state  = 1'b0;
        lfd_state   = 1'b0;
        rst_int_reg = 1'b0;
        data_in     = 8'h00;
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a full packet header 8'h22 + 8 payload bytes + given parity byte, with no FIFO stall.
    task automatic send_packet(input logic [7:0] par_byte, input string tag);
        logic [7:0] payload [8];
        payload = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h22;
        step();
        idle_inputs();
        lfd_state = 1'b1; pkt_valid = 1'b1;
        step();
        vec_cnt++;
        if (data_out !== 8'h22) begin
            err_cnt++;
            $display("FAIL %s header data_out got %h want %h", tag, data_out, 8'h22);
        end
        for (int i = 0; i < 8; i++) begin
            idle_inputs();
            ld_state = 1'b1; pkt_valid = 1'b1; data_in = payload[i];
            step();
            vec_cnt++;
            if (data_out !== payload[i]) begin
                err_cnt++;
                $display("FAIL %s payload[%0d] data_out got %h want %h", tag, i, data_out, payload[i]);
            end
        end
        idle_inputs();
        ld_state = 1'b1; pkt_valid = 1'b0; data_in = par_byte;
        step();
        vec_cnt++;
        if (data_out !== par_byte) begin
            err_cnt++;
            $display("FAIL %s parity data_out got %h want %h", tag, data_out, par_byte);
        end
        vec_cnt++;
        if ({low_pkt_valid, parity_done, err} !== 3'b110) begin
            err_cnt++;
            $display("FAIL %s after parity {lpv,pd,err} got %b want %b", tag,
                     {low_pkt_valid, parity_done, err}, 3'b110);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b1;
        step();
        pkt_valid = 1'b1; ld_state = 1'b1; data_in = 8'h5A; laf_state = 1'b1;
        #2 rstn = 1'b0;
        #1;
        vec_cnt++;
        if ({err, parity_done, low_pkt_valid, data_out} !== 11'h000) begin
            err_cnt++;
            $display("FAIL reset outputs got %b_%b_%b_%h want 0_0_0_00", err, parity_done,
                     low_pkt_valid, data_out);
        end
        step();
        rstn = 1'b1;
        idle_inputs();
        step();
    endtask

    task automatic test_good_packet();
        // 8'h22 ^ 11^22^33^44^55^66^77^88 = 8'hAA
        send_packet(8'hAA, "good");
        vec_cnt++;
        if (err !== 1'b0 || parity_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL good err got %b want 0 (pd got %b want 1)", err, parity_done);
        end
    endtask

    task automatic test_bad_parity();
        send_packet(8'h01, "bad");
        vec_cnt++;
        if (err !== 1'b1) begin
            err_cnt++;
            $display("FAIL bad err got %b want 1", err);
        end
    endtask

    task automatic test_next_packet_clear();
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h11;
        step();
        vec_cnt++;
        if (parity_done !== 1'b0 || low_pkt_valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL clear pd got %b want 0, lpv got %b want 1", parity_done, low_pkt_valid);
        end
        idle_inputs();
        step();
        vec_cnt++;
        if (err !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear err got %b want 0", err);
        end
        rst_int_reg = 1'b1;
        step();
        vec_cnt++;
        if (low_pkt_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL rst_int_reg lpv got %b want 0", low_pkt_valid);
        end
        idle_inputs();
        step();
        vec_cnt++;
        if (err !== 1'b0 || parity_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL clear idle err got %b pd got %b want 0 0", err, parity_done);
        end
    endtask

    task automatic test_fifo_full();
        // header 05, payload 3C, A5 -> parity 05^3C^A5 = 8'h9C
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h05;
        step();
        idle_inputs();
        lfd_state = 1'b1; pkt_valid = 1'b1;
        step();
        idle_inputs();
        ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h3C;
        step();
        vec_cnt++;
        if (data_out !== 8'h3C) begin
            err_cnt++;
            $display("FAIL ff first payload got %h want %h", data_out, 8'h3C);
        end
        ld_state = 1'b1; pkt_valid = 1'b1; fifo_full = 1'b1; data_in = 8'hA5;
        step();
        vec_cnt++;
        if (data_out !== 8'h3C) begin
            err_cnt++;
            $display("FAIL ff hold got %h want %h", data_out, 8'h3C);
        end
        idle_inputs();
        laf_state = 1'b1; pkt_valid = 1'b1;
        step();
        vec_cnt++;
        if (data_out !== 8'hA5) begin
            err_cnt++;
            $display("FAIL ff laf got %h want %h", data_out, 8'hA5);
        end
        idle_inputs();
        ld_state = 1'b1; pkt_valid = 1'b0; fifo_full = 1'b1; data_in = 8'h9C;
        step();
        vec_cnt++;
        if ({data_out, low_pkt_valid, parity_done} !== {8'hA5, 1'b1, 1'b0}) begin
            err_cnt++;
            $display("FAIL ff parity stalled {do,lpv,pd} got %h %b %b want a5 1 0", data_out,
                     low_pkt_valid, parity_done);
        end
        idle_inputs();
        laf_state = 1'b1; pkt_valid = 1'b0;
        step();
        vec_cnt++;
        if (data_out !== 8'h9C || parity_done !== 1'b1) begin
            err_cnt++;
            $display("FAIL ff laf parity do got %h pd got %b want 9c 1", data_out, parity_done);
        end
        idle_inputs();
        step();
        vec_cnt++;
        if (err !== 1'b0) begin
            err_cnt++;
            $display("FAIL ff err got %b want 0", err);
        end
        rst_int_reg = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_invalid_address();
        idle_inputs();
        detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h23;
        step();
        idle_inputs();
        lfd_state = 1'b1; pkt_valid = 1'b1;
        step();
        vec_cnt++;
        if (data_out !== 8'h05) begin
            err_cnt++;
            $display("FAIL invalid addr data_out got %h want %h", data_out, 8'h05);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_midpacket_reset();
        idle_inputs();
        ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'hC3;
        step();
        vec_cnt++;
        if (data_out !== 8'hC3) begin
            err_cnt++;
            $display("FAIL midpkt load got %h want %h", data_out, 8'hC3);
        end
        #3 rstn = 1'b0;
        #1;
        vec_cnt++;
        if (data_out !== 8'h00) begin
            err_cnt++;
            $display("FAIL midpkt async reset data_out got %h want 00", data_out);
        end
        step();
        rstn = 1'b1;
        idle_inputs();
        lfd_state = 1'b1;
        step();
        vec_cnt++;
        if (data_out !== 8'h00) begin
            err_cnt++;
            $display("FAIL midpkt header cleared got %h want 00", data_out);
        end
        idle_inputs();
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        test_reset();
        test_good_packet();
        test_bad_parity();
        test_next_packet_clear();
        test_fifo_full();
        test_invalid_address();
        test_midpacket_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
